// File: rtl/axi_line_pkg.sv
// axi_line_pkg: shared types and helpers for the AXI line master
package axi_line_pkg;
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  function automatic logic [7:0] burst_len(input int words);
    return 8'(words - 1);
  endfunction
endpackage

// File: rtl/axi_line_master.sv
// axi_line_master: moves one cache line per request over an AXI4 INCR burst
module axi_line_master
  import axi_line_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int IW = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_start,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_word_valid,
  output logic [IW-1:0]     rd_word_idx,
  output logic [DATA_W-1:0] rd_word,
  output logic [IW-1:0]     wr_word_idx,
  input  logic [DATA_W-1:0] wr_word,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  output logic              WLAST,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY
);
  localparam logic [IW-1:0] LAST = IW'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
  state_t state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d, rdi_q, rdi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] len_q, len_d;
  logic [DATA_W-1:0] rdw_q, rdw_d;
  logic err_q, err_d, done_q, done_d, rdv_q, rdv_d;
  logic last;
  assign last = cnt_q == LAST;
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign err = err_q;
  assign rd_word_valid = rdv_q;
  assign rd_word_idx = rdi_q;
  assign rd_word = rdw_q;
  assign wr_word_idx = cnt_q;
  assign ARADDR = addr_q;
  assign AWADDR = addr_q;
  assign ARLEN = len_q;
  assign AWLEN = len_q;
  assign ARVALID = state_q == S_AR;
  assign RREADY = state_q == S_R;
  assign AWVALID = state_q == S_AW;
  assign WVALID = state_q == S_W;
  assign BREADY = state_q == S_B;
  assign WLAST = (state_q == S_W) && last;
  assign WDATA = wr_word;
  // Next-state, beat counting and status for one line transfer
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    len_d = len_q;
    err_d = err_q;
    done_d = 1'b0;
    rdv_d = 1'b0;
    rdw_d = rdw_q;
    rdi_d = rdi_q;
    case (state_q)
      S_IDLE: if (req_start) begin
        state_d = req_wr ? S_AW : S_AR;
        addr_d = req_addr & ~OFF_MASK;
        len_d = burst_len(LINE_WORDS);
        err_d = 1'b0;
        cnt_d = '0;
      end
      S_AR: state_d = ARREADY ? S_R : S_AR;
      S_R: if (RVALID) begin
        rdv_d = 1'b1;
        rdw_d = RDATA;
        rdi_d = cnt_q;
        cnt_d = cnt_q + 1'b1;
        err_d = err_q | (RLAST != last);
        state_d = last ? S_IDLE : S_R;
        done_d = last;
      end
      S_AW: state_d = AWREADY ? S_W : S_AW;
      S_W: if (WREADY) begin
        cnt_d = cnt_q + 1'b1;
        state_d = last ? S_B : S_W;
      end
      S_B: if (BVALID) begin
        err_d = BRESP != RESP_OKAY;
        done_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      rdv_q <= 1'b0;
      rdw_q <= '0;
      rdi_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      len_q <= len_d;
      err_q <= err_d;
      done_q <= done_d;
      rdv_q <= rdv_d;
      rdw_q <= rdw_d;
      rdi_q <= rdi_d;
    end
  end
endmodule

// File: tb/tb_axi_line_master.sv
// tb_axi_line_master: directed bench with a small AXI slave RAM and cache model
module tb_axi_line_master;
  logic clk, reset, req_start, req_wr;
  logic [31:0] req_addr;
  logic busy, done, err, rd_word_valid;
  logic [1:0] rd_word_idx, wr_word_idx;
  logic [31:0] rd_word, wr_word;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [7:0] AWLEN, ARLEN;
  logic AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [1:0] BRESP;

  axi_line_master #(.LINE_WORDS(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req_start(req_start), .req_wr(req_wr), .req_addr(req_addr),
    .busy(busy), .done(done), .err(err), .rd_word_valid(rd_word_valid),
    .rd_word_idx(rd_word_idx), .rd_word(rd_word), .wr_word_idx(wr_word_idx), .wr_word(wr_word),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // cache line presented for write-back: word i = 0xA0 + i
  assign wr_word = 32'hA0 + 32'(wr_word_idx);

  // slave configuration
  int ar_delay = 0;
  int r_early = 99;
  bit r_gap = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;

  // slave state: 16-word RAM at byte addresses 0x00..0x3C
  logic [31:0] mem [0:15];
  logic [3:0] r_base, w_base, wlast_bits;
  logic [1:0] r_beat, w_beat;
  logic r_act, r_ph, bv;
  int ar_wait;

  assign ARREADY = ARVALID && (ar_wait >= ar_delay);
  assign RVALID = r_act && !(r_gap && r_ph);
  assign RDATA = mem[r_base + 4'(r_beat)];
  assign RLAST = RVALID && (r_beat == 2'd3 || int'(r_beat) == r_early);
  assign AWREADY = AWVALID;
  assign WREADY = 1'b1;
  assign BVALID = bv;
  assign BRESP = bresp_cfg;

  always @(posedge clk) begin
    if (reset) begin
      mem[4] <= 32'h11; mem[5] <= 32'h22; mem[6] <= 32'h33; mem[7] <= 32'h44;
      r_act <= 1'b0; r_ph <= 1'b0; bv <= 1'b0; ar_wait <= 0;
      r_beat <= '0; w_beat <= '0; r_base <= '0; w_base <= '0; wlast_bits <= '0;
    end else begin
      ar_wait <= (ARVALID && !ARREADY) ? ar_wait + 1 : 0;
      r_ph <= ~r_ph;
      if (ARVALID && ARREADY) begin
        r_act <= 1'b1; r_beat <= '0; r_base <= ARADDR[5:2];
      end else if (RVALID && RREADY) begin
        r_beat <= r_beat + 2'd1;
        if (r_beat == 2'd3) r_act <= 1'b0;
      end
      if (AWVALID && AWREADY) begin
        w_base <= AWADDR[5:2]; w_beat <= '0; wlast_bits <= '0;
      end else if (WVALID && WREADY) begin
        mem[w_base + 4'(w_beat)] <= WDATA;
        wlast_bits[w_beat] <= WLAST;
        w_beat <= w_beat + 2'd1;
        if (WLAST) bv <= 1'b1;
      end
      if (bv && BREADY) bv <= 1'b0;
    end
  end

  // bus monitor sampled on the falling edge
  logic [1:0] rd_idx_q[$];
  logic [31:0] rd_dat_q[$];
  int done_cnt = 0, ar_hs = 0, w_hs = 0, ar_unstable = 0;
  logic [31:0] ar_addr_seen = '0, aw_addr_seen = '0, p_ara = '0;
  logic [7:0] ar_len_seen = '0, aw_len_seen = '0, p_arl = '0;
  logic p_arv = 1'b0, p_arr = 1'b0;
  always @(negedge clk) begin
    if (rd_word_valid) begin
      rd_idx_q.push_back(rd_word_idx);
      rd_dat_q.push_back(rd_word);
    end
    if (done) done_cnt++;
    if (ARVALID && ARREADY) ar_hs++;
    if (WVALID && WREADY) w_hs++;
    if (ARVALID) begin ar_addr_seen = ARADDR; ar_len_seen = ARLEN; end
    if (AWVALID) begin aw_addr_seen = AWADDR; aw_len_seen = AWLEN; end
    if (p_arv && !p_arr && (!ARVALID || ARADDR != p_ara || ARLEN != p_arl)) ar_unstable++;
    p_arv = ARVALID; p_arr = ARREADY; p_ara = ARADDR; p_arl = ARLEN;
  end

  int vecs = 0, errs = 0;
  int start = 0, lat = 0, rb = 0, db = 0, ab = 0, wb = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [31:0] a);
    @(negedge clk);
    req_start = 1'b1; req_wr = wr; req_addr = a;
    start = cyc;
    rb = rd_idx_q.size(); db = done_cnt; ab = ar_hs; wb = w_hs;
    @(posedge clk); #1;
    req_start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    lat = done ? cyc - start + 1 : -1;
    check("done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic check_reads(input string tag);
    repeat (2) @(negedge clk);
    check({tag, "_cnt"}, 64'(rd_idx_q.size() - rb), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_idx"}, {62'd0, rd_idx_q[rb + i]}, 64'(i));
      check({tag, "_dat"}, {32'd0, rd_dat_q[rb + i]}, 64'(32'h11 * (i + 1)));
    end
  endtask

  initial begin
    reset = 1'b1; req_start = 1'b0; req_wr = 1'b0; req_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_arvalid", {63'd0, ARVALID}, 64'd0);
    check("rst_araddr", {32'd0, ARADDR}, 64'd0);
    check("rst_arlen", {56'd0, ARLEN}, 64'd0);
    check("rst_rdv", {63'd0, rd_word_valid}, 64'd0);
    @(negedge clk) reset = 1'b0;

    // 1: zero-wait read inside line 0x10
    do_req(1'b0, 32'h14);
    wait_done();
    check("rd1_lat", 64'(lat), 64'd7);
    check("rd1_err", {63'd0, err}, 64'd0);
    check("rd1_busy", {63'd0, busy}, 64'd0);
    check_reads("rd1");
    check("rd1_araddr", {32'd0, ar_addr_seen}, 64'h10);
    check("rd1_arlen", {56'd0, ar_len_seen}, 64'd3);

    // 2: zero-wait write-back to line 0x20
    do_req(1'b1, 32'h20);
    wait_done();
    check("wr_lat", 64'(lat), 64'd8);
    check("wr_err", {63'd0, err}, 64'd0);
    @(negedge clk);
    check("wr_awaddr", {32'd0, aw_addr_seen}, 64'h20);
    check("wr_awlen", {56'd0, aw_len_seen}, 64'd3);
    check("wr_beats", 64'(w_hs - wb), 64'd4);
    check("wr_wlast", {60'd0, wlast_bits}, 64'b1000);
    for (int i = 0; i < 4; i++) check("wr_mem", {32'd0, mem[8 + i]}, 64'(32'hA0 + i));

    // 3: ARREADY delayed, RVALID gapped
    ar_delay = 3; r_gap = 1'b1;
    do_req(1'b0, 32'h1C);
    wait_done();
    check("gap_err", {63'd0, err}, 64'd0);
    check_reads("gap");
    check("gap_ar_stable", 64'(ar_unstable), 64'd0);
    check("gap_done_once", 64'(done_cnt - db), 64'd1);
    check("gap_ar_once", 64'(ar_hs - ab), 64'd1);
    ar_delay = 0; r_gap = 1'b0;

    // 4: error response on write, cleared by next accept
    bresp_cfg = 2'b10;
    do_req(1'b1, 32'h30);
    wait_done();
    check("bresp_err", {63'd0, err}, 64'd1);
    bresp_cfg = 2'b00;
    do_req(1'b0, 32'h10);
    check("accept_clr_err", {63'd0, err}, 64'd0);
    wait_done();
    check("bresp_next_err", {63'd0, err}, 64'd0);
    check_reads("rd4");

    // 5: early RLAST and a request while busy
    r_early = 1;
    do_req(1'b0, 32'h18);
    @(negedge clk) req_start = 1'b1;
    @(negedge clk) req_start = 1'b0;
    wait_done();
    check("early_err", {63'd0, err}, 64'd1);
    check_reads("early");
    repeat (3) @(negedge clk);
    check("early_ar_once", 64'(ar_hs - ab), 64'd1);
    check("early_busy", {63'd0, busy}, 64'd0);
    r_early = 99;

    // 6: reset in the middle of a W burst
    do_req(1'b1, 32'h3C);
    for (int i = 0; i < 20; i++) begin
      if (WVALID && wr_word_idx == 2'd2) break;
      @(posedge clk); #1;
    end
    check("mid_w_reached", {62'd0, wr_word_idx}, 64'd2);
    reset = 1'b1;
    #1;
    check("mrst_wvalid", {63'd0, WVALID}, 64'd0);
    check("mrst_busy", {63'd0, busy}, 64'd0);
    check("mrst_done", {63'd0, done}, 64'd0);
    check("mrst_awaddr", {32'd0, AWADDR}, 64'd0);
    check("mrst_awlen", {56'd0, AWLEN}, 64'd0);
    check("mrst_widx", {62'd0, wr_word_idx}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    do_req(1'b0, 32'h14);
    wait_done();
    check("post_lat", 64'(lat), 64'd7);
    check("post_err", {63'd0, err}, 64'd0);
    check_reads("post");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/axi_line_master.md
# axi_line_master

Single-port AXI4 burst master that moves one cache line per request between a cache/TLB refill controller and an AXI slave memory (the `axi_slave_module` RAMs on the instruction and data buses). A read request issues one INCR burst on AR/R and streams the returned words to the cache. A write-back request issues AW, then a W burst, then collects B. One instance sits behind the instruction cache and one behind the data cache inside `pipeline_cpu`, driving the `M_AXI_INSTR_*` / `M_AXI_DATA_*` ports.

## Interface
- `LINE_WORDS`, 4: words per line and per burst; power of two, 2..16.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; one word per beat.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_start`  in  1  request strobe; sampled only in IDLE.
- `req_wr`  in  1  0 = line read (refill), 1 = line write-back.
- `req_addr`  in  ADDR_W  any byte address inside the line.
- `busy`  out  1  high from accept until the cycle done pulses.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  status, valid while done=1; held until next accept.
- `rd_word_valid`  out  1  one-cycle pulse per returned read word.
- `rd_word_idx`  out  log2(LINE_WORDS)  index of the returned word.
- `rd_word`  out  DATA_W  returned read word.
- `wr_word_idx`  out  log2(LINE_WORDS)  index of the word the cache must present.
- `wr_word`  in  DATA_W  cache data for wr_word_idx, combinational.
- AXI master ports: `AWADDR`/ADDR_W, `AWLEN`/8, `AWVALID`, `AWREADY`, `WDATA`/DATA_W, `WVALID`, `WLAST`, `WREADY`, `BRESP`/2, `BVALID`, `BREADY`, `ARADDR`/ADDR_W, `ARLEN`/8, `ARVALID`, `ARREADY`, `RDATA`/DATA_W, `RLAST`, `RVALID`, `RREADY`. Directions follow the AXI master convention. Size, burst type and strobes are fixed by the top level (word size, INCR, all strobes set).

## Operation
- States:
  - IDLE: if req_start=1, go to AR when req_wr=0, else to AW.
  - AR: ARVALID=1; on ARREADY go to R.
  - R: RREADY=1.
  - AW: AWVALID=1; on AWREADY go to W.
  - W: WVALID=1.
  - B: BREADY=1; on BVALID go to IDLE.
- Accept: the registered line address is req_addr with its low log2(LINE_WORDS*4) bits cleared. Accept also clears err and the beat counter.
- ARADDR and AWADDR are the line address. ARLEN and AWLEN are LINE_WORDS-1.
- R state, per handshake (RVALID & RREADY):
  - rd_word = RDATA and rd_word_idx = beat counter, registered with rd_word_valid.
  - The beat counter increments.
  - On the beat where counter = LINE_WORDS-1, go to IDLE and pulse done.
  - RLAST must be 1 exactly on that beat. If RLAST=1 early, set err=1 and count the beat normally. If RLAST=0 on the final beat, set err=1.
- W state:
  - WDATA = wr_word, driven combinationally.
  - wr_word_idx = beat counter.
  - WLAST = (counter = LINE_WORDS-1).
  - Each WVALID & WREADY increments the counter. The last handshake moves to B.
- B state: on the BVALID handshake, set err = (BRESP ≠ 2'b00) and pulse done.
- req_start outside IDLE is ignored; it is not queued.
- Reset (asynchronous), applied at any time including mid-burst:
  - State goes to IDLE and the counter to 0.
  - All VALID/READY outputs, busy, done, err and rd_word_valid go to 0.
  - Address, LEN, rd_word and rd_word_idx go to 0.

## Timing
- All outputs are registered except WDATA, which follows wr_word.
- With a zero-wait slave, a read takes accept, then AR (ARREADY in the same cycle), then LINE_WORDS R beats. done and the last rd_word_valid occur in the cycle after the final beat: LINE_WORDS+3 cycles from the req_start edge.
- A zero-wait write takes LINE_WORDS+4 cycles.
- Once VALID is asserted it holds, with ADDR/LEN/WDATA/WLAST stable, until its READY. VALID never waits on READY.
- READY/VALID gaps on the slave side only stretch the corresponding state. No beat is lost or duplicated.
- busy drops in the same cycle done pulses. A new req_start is accepted in the cycle after done.

## Structure
- Package `axi_line_pkg` holds:
  - the state enum (IDLE, AR, R, AW, W, B);
  - RESP_OKAY = 2'b00;
  - a function deriving LEN from LINE_WORDS.
- No sub-module. The beat counter and FSM live in one file.

## Test plan
- Read at req_addr=0x0000_0014, zero-wait slave preloaded with 0x11,0x22,0x33,0x44 at 0x10..0x1C -> ARADDR=0x10, ARLEN=3; rd_word idx 0..3 = 0x11..0x44; done at cycle 7; err=0.
- Write-back at 0x0000_0020 with the cache line A0..A3 -> AWADDR=0x20, AWLEN=3; 4 W beats with WLAST only on the 4th; slave RAM holds A0..A3; done after BVALID; err=0.
- ARREADY delayed 3 cycles and RVALID low every other cycle -> ARVALID/ARADDR stable throughout; exactly 4 rd_word_valid pulses in order; done once.
- Slave returns BRESP=2'b10 -> done=1 with err=1; next read accept clears err.
- RLAST forced on beat 1 -> err=1 at done; a req_start during busy produces no second AR.
- Reset asserted mid-W at beat 2 -> WVALID, busy and done are 0 immediately; after release, a new read completes normally.
